// File: rtl/mips_core_pkg.sv
// Shared register-file constants for rename, the physical register file and
// the free list.
package mips_core_pkg;

    localparam int PHY_REG_COUNT  = 64;
    localparam int ARCH_REG_COUNT = 32;
    localparam int PHY_REG_WIDTH  = 6;

    typedef logic [PHY_REG_WIDTH-1:0] phy_reg_t;

endpackage : mips_core_pkg

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical registers. It has a speculative allocation
// head, a commit head for flush rewind, and a tail for reclaimed registers.
module phys_reg_free_list
    import mips_core_pkg::*;
#(
    parameter int NUM_PHY_REGS  = PHY_REG_COUNT,
    parameter int NUM_ARCH_REGS = ARCH_REG_COUNT,
    parameter int FL_DEPTH      = NUM_PHY_REGS - NUM_ARCH_REGS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_req,
    output logic                     alloc_grant,
    output logic [PHY_REG_WIDTH-1:0] alloc_phy,
    input  logic                     retire_valid,
    input  logic                     retire_has_dst,
    input  logic [PHY_REG_WIDTH-1:0] retire_old_phy,
    input  logic                     flush,
    output logic [PHY_REG_WIDTH-1:0] free_count,
    output logic                     fl_empty,
    output logic                     fl_error
);

    localparam int IDX_W = $clog2(FL_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] FULL_OCC = PTR_W'(FL_DEPTH);

    phy_reg_t         fl_mem [FL_DEPTH];
    logic [PTR_W-1:0] spec_head;
    logic [PTR_W-1:0] commit_head;
    logic [PTR_W-1:0] tail;

    logic             retire_push;
    logic             zero_phy;
    logic             overflow;
    logic             push_ok;
    logic             commit_adv;
    logic [PTR_W-1:0] commit_head_nxt;

    assign free_count  = PHY_REG_WIDTH'(tail - spec_head);
    assign fl_empty    = (free_count == '0);
    assign alloc_grant = alloc_req & ~fl_empty & ~flush & ~rst;
    assign alloc_phy   = fl_mem[spec_head[IDX_W-1:0]];

    // The retiring instruction vacates the commit_head slot, so a push with
    // tail - commit_head == FL_DEPTH only overflows when there is no
    // uncommitted allocation for this retire to free.
    assign retire_push     = retire_valid & retire_has_dst;
    assign zero_phy        = (retire_old_phy == '0);
    assign overflow        = ((tail - commit_head) == FULL_OCC) && (commit_head == spec_head);
    assign push_ok         = retire_push & ~zero_phy & ~overflow;
    assign commit_adv      = retire_push & ~overflow;
    assign commit_head_nxt = commit_adv ? commit_head + 1'b1 : commit_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fl_mem[i] <= phy_reg_t'(NUM_ARCH_REGS + i);
            end
            spec_head   <= '0;
            commit_head <= '0;
            tail        <= FULL_OCC;
            fl_error    <= 1'b0;
        end else begin
            if (push_ok) begin
                fl_mem[tail[IDX_W-1:0]] <= retire_old_phy;
                tail                    <= tail + 1'b1;
            end
            commit_head <= commit_head_nxt;
            if (flush) begin
                spec_head <= commit_head_nxt;
            end else if (alloc_grant) begin
                spec_head <= spec_head + 1'b1;
            end
            if (retire_push && (zero_phy || overflow)) begin
                fl_error <= 1'b1;
            end
        end
    end

endmodule : phys_reg_free_list

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list. Grant expectations are queued by
// the stimulus and popped by a negedge monitor.
module tb_phys_reg_free_list;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alloc_req = 1'b0;
    logic       alloc_grant;
    logic [5:0] alloc_phy;
    logic       retire_valid = 1'b0;
    logic       retire_has_dst = 1'b0;
    logic [5:0] retire_old_phy = '0;
    logic       flush = 1'b0;
    logic [5:0] free_count;
    logic       fl_empty;
    logic       fl_error;

    int n_cmp = 0;
    int n_bad = 0;
    logic [6:0] exp_q[$];

    phys_reg_free_list dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_req     (alloc_req),
        .alloc_grant   (alloc_grant),
        .alloc_phy     (alloc_phy),
        .retire_valid  (retire_valid),
        .retire_has_dst(retire_has_dst),
        .retire_old_phy(retire_old_phy),
        .flush         (flush),
        .free_count    (free_count),
        .fl_empty      (fl_empty),
        .fl_error      (fl_error)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle with a request presents a grant decision.
    always @(negedge clk) begin
        if (alloc_req) begin
            logic [6:0] e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL grant_unexpected: got grant=%0b phy=%0d, required no request pending",
                         alloc_grant, alloc_phy);
            end else begin
                e = exp_q.pop_front();
                if (alloc_grant !== e[6] || (e[6] && alloc_phy !== e[5:0])) begin
                    n_bad++;
                    $display("FAIL grant @%0t: got grant=%0b phy=%0d, required grant=%0b phy=%0d",
                             $time, alloc_grant, alloc_phy, e[6], e[5:0]);
                end
            end
        end
    end

    task automatic drive(input logic req, input logic rv, input logic dst,
                         input logic [5:0] old, input logic fl,
                         input logic eg, input logic [5:0] ep);
        alloc_req      = req;
        retire_valid   = rv;
        retire_has_dst = dst;
        retire_old_phy = old;
        flush          = fl;
        if (req) exp_q.push_back({eg, ep});
        @(posedge clk);
        #1;
        alloc_req      = 1'b0;
        retire_valid   = 1'b0;
        retire_has_dst = 1'b0;
        retire_old_phy = '0;
        flush          = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 6'd3, 1'b0, 1'b0, 6'd0);
        rst = 1'b0;
    endtask

    task automatic check_status(input string nm, input int fc, input logic emp, input logic err);
        n_cmp++;
        if (free_count !== 6'(fc) || fl_empty !== emp || fl_error !== err) begin
            n_bad++;
            $display("FAIL %s: got fc=%0d empty=%0b err=%0b, required fc=%0d empty=%0b err=%0b",
                     nm, free_count, fl_empty, fl_error, fc, emp, err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] pushed[$];
        @(posedge clk);
        #1;
        // Reset state; request during reset must not be granted.
        do_reset();
        check_status("reset", 32, 1'b0, 1'b0);

        // Retire without destination: no state change, phy 0 is not an error.
        drive(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        check_status("retire_no_dst", 32, 1'b0, 1'b0);

        // Drain: 32 grants of 32..63, then empty.
        for (int i = 0; i < 32; i++) drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'(32 + i));
        check_status("drained", 0, 1'b1, 1'b0);
        // Empty + retire same cycle: no bypass.
        drive(1'b1, 1'b1, 1'b1, 6'd5, 1'b0, 1'b0, 6'd0);
        check_status("reclaim_5", 1, 1'b0, 1'b0);
        // free_count = 1 with alloc and retire together.
        drive(1'b1, 1'b1, 1'b1, 6'd6, 1'b0, 1'b1, 6'd5);
        check_status("fc1_alloc_retire", 1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd6);
        check_status("empty_again", 0, 1'b1, 1'b0);
        // Flush while empty rewinds to the commit point.
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0);
        check_status("flush_empty", 32, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd34);

        // Flush in the same cycle as a retire.
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'(32 + i));
        check_status("alloc4", 28, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 6'd7, 1'b1, 1'b0, 6'd0);
        check_status("flush_retire", 32, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd33);

        // Retire of phy 0: error, no push, commit_head still advances.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd32);
        drive(1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0, 6'd0);
        check_status("zero_phy", 31, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 6'd0);
        check_status("zero_phy_flush", 31, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd33);
        drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0);
        check_status("error_sticky", 30, 1'b0, 1'b1);
        do_reset();
        check_status("error_cleared", 32, 1'b0, 1'b0);

        // Overflow: retire with nothing allocated is dropped.
        drive(1'b0, 1'b1, 1'b1, 6'd9, 1'b0, 1'b0, 6'd0);
        check_status("overflow", 32, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd32);

        // Steady alloc + retire for 100 cycles across pointer wrap.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd32);
        for (int k = 0; k < 100; k++) begin
            logic [5:0] old;
            logic [5:0] ep;
            old = 6'((k % 63) + 1);
            ep  = (k < 31) ? 6'(33 + k) : pushed[k - 31];
            pushed.push_back(old);
            drive(1'b1, 1'b1, 1'b1, old, 1'b0, 1'b1, ep);
            if (k == 50 || k == 99) check_status("steady", 31, 1'b0, 1'b0);
        end

        // Reset with 10 allocations outstanding.
        do_reset();
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'(32 + i));
        check_status("alloc10", 22, 1'b0, 1'b0);
        do_reset();
        check_status("mid_reset", 32, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 6'd32);

        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_phys_reg_free_list
